// File: rtl/usr_seq_ctrl_pkg.sv
// Shared constants for the USR command sequencer.
//   - op codes carried on cmd_op (6 and 7 are rejected)
//   - USR mode select encodings {s1,s0}
//   - sequencer state encoding
package usr_ctrl_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SHL   = 3'd1;
    localparam logic [OP_W-1:0] OP_SHR   = 3'd2;
    localparam logic [OP_W-1:0] OP_ROL   = 3'd3;
    localparam logic [OP_W-1:0] OP_ROR   = 3'd4;
    localparam logic [OP_W-1:0] OP_CLEAR = 3'd5;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Requester-side command/response bundle of the USR sequencer.
//   master : the host issuing commands (drives cmd_*, observes status/result)
//   slave  : the sequencer (accepts cmd_*, drives ready/busy/done/err/result)
interface usr_seq_ctrl_if
    import usr_ctrl_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int CW   = $clog2(SIZE + 1) + 1
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [OP_W-1:0] cmd_op;
    logic [CW-1:0]   cmd_cnt;
    logic [SIZE-1:0] cmd_data;
    logic            cmd_fill;
    logic            busy;
    logic            done;
    logic            err;
    logic [SIZE-1:0] result;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill,
        input  cmd_ready, busy, done, err, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill,
        output cmd_ready, busy, done, err, result
    );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for an external universal shift register.
// Accepts one command at a time, steps the USR mode selects for the
// required number of cycles, then returns the captured USR word with a
// one-cycle done pulse (or a one-cycle err pulse for a rejected command).
// Ports:
//   clk, clr        clock (rising) and asynchronous active-low reset
//   cmd_if          command handshake, status and result (slave side)
//   usr_par_out     feedback from the USR parallel output
//   usr_s1/usr_s0   USR mode select
//   usr_lsb_in      serial input for left shifts
//   usr_msb_in      serial input for right shifts
//   usr_par_in      parallel load word
module usr_seq_ctrl
    import usr_ctrl_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int CW   = $clog2(SIZE + 1) + 1
) (
    input  logic            clk,
    input  logic            clr,
    usr_seq_ctrl_if.slave   cmd_if,
    input  logic [SIZE-1:0] usr_par_out,
    output logic            usr_s1,
    output logic            usr_s0,
    output logic            usr_lsb_in,
    output logic            usr_msb_in,
    output logic [SIZE-1:0] usr_par_in
);

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            fill_q, fill_d;
    logic [SIZE-1:0] result_q, result_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      mode;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        fill_d     = fill_q;
        result_d   = result_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mode       = MODE_HOLD;
        usr_lsb_in = 1'b0;
        usr_msb_in = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    // Rejected commands leave every latch untouched so the
                    // USR sees no activity at all.
                    if (cmd_if.cmd_op > OP_CLEAR || cmd_if.cmd_cnt > CW'(SIZE)) begin
                        err_d = 1'b1;
                    end else begin
                        op_d   = cmd_if.cmd_op;
                        cnt_d  = cmd_if.cmd_cnt;
                        fill_d = cmd_if.cmd_fill;
                        data_d = (cmd_if.cmd_op == OP_CLEAR) ? '0 : cmd_if.cmd_data;
                        if (cmd_if.cmd_op == OP_LOAD || cmd_if.cmd_op == OP_CLEAR)
                            state_d = ST_LOAD;
                        else if (cmd_if.cmd_cnt == '0)
                            state_d = ST_FINISH;
                        else
                            state_d = ST_SHIFT;
                    end
                end
            end
            ST_LOAD: begin
                mode    = MODE_LOAD;
                state_d = ST_FINISH;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - CW'(1);
                // Leaving on count==1 yields exactly cnt shift cycles.
                if (cnt_q == CW'(1))
                    state_d = ST_FINISH;
                // Rotates feed the outgoing bit straight back from the USR.
                case (op_q)
                    OP_SHL: begin mode = MODE_SHL; usr_lsb_in = fill_q;                end
                    OP_ROL: begin mode = MODE_SHL; usr_lsb_in = usr_par_out[SIZE-1];   end
                    OP_SHR: begin mode = MODE_SHR; usr_msb_in = fill_q;                end
                    OP_ROR: begin mode = MODE_SHR; usr_msb_in = usr_par_out[0];        end
                    default: ;
                endcase
            end
            ST_FINISH: begin
                result_d = usr_par_out;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign usr_s1     = mode[1];
    assign usr_s0     = mode[0];
    assign usr_par_in = data_q;

    assign cmd_if.cmd_ready = (state_q == ST_IDLE);
    assign cmd_if.busy      = (state_q != ST_IDLE);
    assign cmd_if.done      = done_q;
    assign cmd_if.err       = err_q;
    assign cmd_if.result    = result_q;

endmodule
